// File: rtl/wb_gpio_bank.sv
// rtl/wb_gpio_bank.sv - Wishbone GPIO bank with direction, open-drain, atomic set/clear and edge interrupts
module wb_gpio_bank #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_dat,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);
    localparam logic [3:0] A_IN   = 4'd0;
    localparam logic [3:0] A_OUT  = 4'd1;
    localparam logic [3:0] A_DIR  = 4'd2;
    localparam logic [3:0] A_OD   = 4'd3;
    localparam logic [3:0] A_IE   = 4'd4;
    localparam logic [3:0] A_RISE = 4'd5;
    localparam logic [3:0] A_FALL = 4'd6;
    localparam logic [3:0] A_ISR  = 4'd7;
    localparam logic [3:0] A_SET  = 4'd8;
    localparam logic [3:0] A_CLR  = 4'd9;

    logic [WIDTH-1:0] out_r, dir_r, od_r, ie_r, rise_r, fall_r, isr_r, prev_r;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] sync_in, rise_evt, fall_evt, set_evt, isr_clr;
    logic [WIDTH-1:0] wmask, wbits;
    logic [31:0]      sel_mask, rd_data;
    logic             acc, wr;
    logic             unused_ok;

    // A new access is only accepted while ack is low, giving one ack per access.
    assign acc      = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr       = acc & i_wb_we;
    assign sel_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign wmask    = sel_mask[WIDTH-1:0];
    assign wbits    = i_wb_dat[WIDTH-1:0] & wmask;
    assign unused_ok = ^{i_wb_dat, sel_mask};

    assign sync_in  = sync_r[SYNC_STAGES-1];
    assign rise_evt = sync_in & ~prev_r;
    assign fall_evt = ~sync_in & prev_r;
    assign set_evt  = (rise_evt & rise_r) | (fall_evt & fall_r);
    assign isr_clr  = (wr && i_wb_adr == A_ISR) ? wbits : '0;

    // Open-drain bits only ever pull low: the enable carries the data.
    assign o_gpio    = out_r & ~od_r;
    assign o_gpio_oe = dir_r & ~(od_r & out_r);

    always_comb begin
        rd_data = '0;
        case (i_wb_adr)
            A_IN:    rd_data[WIDTH-1:0] = sync_in;
            A_OUT:   rd_data[WIDTH-1:0] = out_r;
            A_DIR:   rd_data[WIDTH-1:0] = dir_r;
            A_OD:    rd_data[WIDTH-1:0] = od_r;
            A_IE:    rd_data[WIDTH-1:0] = ie_r;
            A_RISE:  rd_data[WIDTH-1:0] = rise_r;
            A_FALL:  rd_data[WIDTH-1:0] = fall_r;
            A_ISR:   rd_data[WIDTH-1:0] = isr_r;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_r    <= RESET_OUT;
            dir_r    <= RESET_DIR;
            od_r     <= '0;
            ie_r     <= '0;
            rise_r   <= '0;
            fall_r   <= '0;
            isr_r    <= '0;
            prev_r   <= '0;
            sync_r   <= '0;
            o_wb_ack <= 1'b0;
            o_wb_dat <= '0;
            o_irq    <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], i_gpio};
            prev_r   <= sync_in;
            // Set events take priority over a coincident write-1-to-clear.
            isr_r    <= (isr_r & ~isr_clr) | set_evt;
            o_irq    <= |(isr_r & ie_r);
            o_wb_ack <= acc;
            o_wb_dat <= (acc & ~i_wb_we) ? rd_data : '0;
            if (wr) begin
                case (i_wb_adr)
                    A_OUT:   out_r  <= (out_r & ~wmask) | wbits;
                    A_DIR:   dir_r  <= (dir_r & ~wmask) | wbits;
                    A_OD:    od_r   <= (od_r & ~wmask) | wbits;
                    A_IE:    ie_r   <= (ie_r & ~wmask) | wbits;
                    A_RISE:  rise_r <= (rise_r & ~wmask) | wbits;
                    A_FALL:  fall_r <= (fall_r & ~wmask) | wbits;
                    A_SET:   out_r  <= out_r | wbits;
                    A_CLR:   out_r  <= out_r & ~wbits;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wb_gpio_bank.sv
// tb/tb_wb_gpio_bank.sv - directed self-checking bench for wb_gpio_bank
module tb_wb_gpio_bank;
    localparam int W = 16;
    localparam logic [W-1:0] R_OUT = 16'h00C3;
    localparam logic [W-1:0] R_DIR = 16'h0F00;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   adr;
    logic [31:0]  wdat;
    logic [3:0]   sel;
    logic         we, cyc, stb;
    logic [31:0]  rdat;
    logic         ack;
    logic [W-1:0] gpio_in, gpio_out, gpio_oe;
    logic         irq;

    int n_checks = 0;
    int n_err    = 0;
    int lat      = 0;
    logic [31:0] rv;
    logic [31:0] rst_exp [16];

    wb_gpio_bank #(.WIDTH(W), .SYNC_STAGES(2), .RESET_OUT(R_OUT), .RESET_DIR(R_DIR)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_dat(rdat), .o_wb_ack(ack),
        .i_gpio(gpio_in), .o_gpio(gpio_out), .o_gpio_oe(gpio_oe), .o_irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ack is seen high.
    task automatic xfer(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, output logic [31:0] r);
        int n = 0;
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        lat = n;
        r = rdat;
        if (!ack) check("ack_timeout", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        xfer(a, d, s, 1'b1, dummy);
    endtask

    task automatic rdc(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(a, 32'h0, 4'hF, 1'b0, r);
        check(tag, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        gpio_in = '0;
        foreach (rst_exp[i]) rst_exp[i] = 32'h0;
        rst_exp[1] = 32'h0000_00C3;
        rst_exp[2] = 32'h0000_0F00;
        idle(3);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_gpio", {16'd0, gpio_out}, 32'h0000_00C3);
        check("rst_oe", {16'd0, gpio_oe}, 32'h0000_0F00);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 16; i++) begin
            rdc($sformatf("rst_reg%0d", i), i[3:0], rst_exp[i]);
            check($sformatf("rst_lat%0d", i), lat, 32'd1);
            idle(1);
        end

        // Push-pull drive, atomic set/clear, byte enables
        wr(4'd2, 32'h0000_00FF, 4'hF);
        wr(4'd1, 32'h0000_00A5, 4'hF);
        check("pp_oe", {16'd0, gpio_oe}, 32'h0000_00FF);
        check("pp_gpio", {16'd0, gpio_out}, 32'h0000_00A5);
        wr(4'd8, 32'h0000_000A, 4'hF);
        idle(1);
        rdc("set_out", 4'd1, 32'h0000_00AF);
        idle(1);
        wr(4'd9, 32'h0000_0081, 4'hF);
        idle(1);
        rdc("clr_out", 4'd1, 32'h0000_002E);
        idle(1);
        wr(4'd1, 32'h0000_1234, 4'b0001);
        idle(1);
        rdc("sel_out", 4'd1, 32'h0000_0034);
        idle(1);
        wr(4'd8, 32'h0000_FF00, 4'b0001);
        idle(1);
        rdc("set_unsel", 4'd1, 32'h0000_0034);
        idle(1);
        wr(4'd1, 32'hFFFF_FFFF, 4'hF);
        idle(1);
        rdc("out_width", 4'd1, 32'h0000_FFFF);
        idle(1);
        wr(4'd12, 32'hFFFF_FFFF, 4'hF);
        idle(1);
        rdc("hole_rd", 4'd12, 32'h0);
        idle(1);

        // Open-drain
        wr(4'd3, 32'h1, 4'hF);
        idle(1);
        wr(4'd2, 32'h1, 4'hF);
        idle(1);
        wr(4'd1, 32'h0, 4'hF);
        check("od0_gpio", {16'd0, gpio_out}, 32'h0);
        check("od0_oe", {16'd0, gpio_oe}, 32'h1);
        idle(1);
        wr(4'd1, 32'h1, 4'hF);
        check("od1_gpio", {16'd0, gpio_out}, 32'h0);
        check("od1_oe", {16'd0, gpio_oe}, 32'h0);
        idle(1);

        // Rising-edge interrupt and W1C
        wr(4'd5, 32'h4, 4'hF);
        idle(1);
        wr(4'd4, 32'h4, 4'hF);
        idle(1);
        gpio_in = 16'h0004;
        idle(3);
        check("rise_irq_early", {31'd0, irq}, 32'd0);
        idle(1);
        check("rise_irq", {31'd0, irq}, 32'd1);
        rdc("rise_isr", 4'd7, 32'h4);
        idle(1);
        rdc("in_val", 4'd0, 32'h4);
        idle(1);
        wr(4'd7, 32'h4, 4'hF);
        check("w1c_irq_hold", {31'd0, irq}, 32'd1);
        idle(1);
        check("w1c_irq_drop", {31'd0, irq}, 32'd0);
        rdc("w1c_isr", 4'd7, 32'h0);
        idle(1);

        // Falling-edge interrupt, masked then enabled
        wr(4'd4, 32'h0, 4'hF);
        idle(1);
        wr(4'd6, 32'h1, 4'hF);
        idle(1);
        gpio_in = 16'h0005;
        idle(4);
        gpio_in = 16'h0004;
        idle(4);
        rdc("fall_isr", 4'd7, 32'h1);
        check("fall_irq_masked", {31'd0, irq}, 32'd0);
        idle(1);
        wr(4'd4, 32'h1, 4'hF);
        idle(1);
        check("fall_irq_en", {31'd0, irq}, 32'd1);

        // Coincident W1C and set event on bit 3
        wr(4'd5, 32'hC, 4'hF);
        idle(1);
        gpio_in = 16'h000C;
        idle(4);
        gpio_in = 16'h0004;
        idle(4);
        rdc("pre_isr", 4'd7, 32'h9);
        idle(1);
        gpio_in = 16'h000C;
        idle(2);
        wr(4'd7, 32'h8, 4'hF);
        idle(1);
        rdc("coinc_isr", 4'd7, 32'h9);
        idle(1);
        wr(4'd7, 32'h9, 4'hF);
        idle(1);
        rdc("clr_all_isr", 4'd7, 32'h0);
        idle(1);

        // Reset during an active strobe
        adr = 4'd1; wdat = 32'h0000_5A5A; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ack", {31'd0, ack}, 32'd0);
        check("mid_rst_gpio", {16'd0, gpio_out}, 32'h0000_00C3);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        idle(1);
        rdc("mid_rst_out", 4'd1, 32'h0000_00C3);
        idle(1);
        rdc("mid_rst_ie", 4'd4, 32'h0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
